lsu_unit: RTL and testbench
===========================

LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the number of REQ-state cycles without mem_ack before the access is aborted. It SHALL be in the range 1..255.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; asynchronous and active-high.
REQ-004 in_valid  in  1  the upstream (ALU stage) operation is valid.
REQ-005 in_ready  out  1  lsu_unit can accept an operation.
REQ-006 mem_en  in  1  the operation needs memory access; 0 means pass-through.
REQ-007 alu_result  in  64  the ALU result, used as the byte address when mem_en=1.
REQ-008 store_data  in  64  the rs2 value for stores.
REQ-009 mem_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word, 3 dword).
REQ-010 mem_req  out  1  bus request.
REQ-011 mem_we  out  1  bus write.
REQ-012 mem_addr  out  64  the address with bits [2:0] forced to 0.
REQ-013 mem_wdata  out  64  the lane-aligned store data.
REQ-014 mem_wmask  out  8  the byte-write mask.
REQ-015 mem_ack  in  1  bus completion; qualifies mem_rdata.
REQ-016 mem_rdata  in  64  the 8-byte-aligned read data.
REQ-017 out_valid  out  1  the result is valid to the writeback stage.
REQ-018 out_ready  in  1  the writeback stage accepts the result.
REQ-019 out_data  out  64  the load result, the pass-through value, or 0.
REQ-020 out_err  out  1  the access was misaligned or timed out.

Function
REQ-021 FSM states SHALL be IDLE, REQ and DONE; in_ready SHALL equal (state==IDLE).
REQ-022 On acceptance (in_valid & in_ready) the block SHALL latch alu_result, store_data, mem_op and mem_en.
REQ-023 Acceptance with mem_en=0 SHALL go to DONE with out_data=alu_result and out_err=0; out_valid SHALL rise on the next cycle.
REQ-024 Misalignment is defined per size: half when addr[0]!=0, word when addr[1:0]!=0, dword when addr[2:0]!=0; a byte access is never misaligned.
REQ-025 A misaligned access SHALL go straight to DONE with out_err=1 and out_data=0, and mem_req SHALL never assert for it.
REQ-026 A legal access SHALL go to REQ; mem_req SHALL be 1 throughout REQ and 0 in every other state.
REQ-027 mem_addr, mem_we, mem_wdata and mem_wmask SHALL remain stable while in REQ.
REQ-028 Store lane placement: mem_wdata = store_data << (8*addr[2:0]); mem_wmask = ((1<<bytes)-1) << addr[2:0], where bytes = 1, 2, 4 or 8.
REQ-029 During loads, mem_wmask SHALL be 0 and mem_we SHALL be 0.
REQ-030 The load result SHALL be r = mem_rdata >> (8*addr[2:0]), truncated to the access size, then sign-extended (mem_op[2]=0) or zero-extended (mem_op[2]=1) to 64 bits.
REQ-031 Stores SHALL return out_data=0.
REQ-032 When mem_ack=1 in REQ (including the first REQ cycle), the block SHALL capture the result and go to DONE; mem_ack outside REQ SHALL be ignored.
REQ-033 An 8-bit timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-034 When the counter reaches TIMEOUT_CYCLES without ack, the block SHALL go to DONE with out_err=1 and out_data=0.
REQ-035 If ack and timeout occur in the same cycle, the ack SHALL win.
REQ-036 In DONE, out_valid SHALL be 1 and out_data/out_err SHALL be held until out_ready=1.
REQ-037 out_valid & out_ready SHALL return the FSM to IDLE; a new operation SHALL be accepted no earlier than the following cycle.
REQ-038 Latency: with acceptance at cycle T, mem_req SHALL assert at T+1; an ack at T+k SHALL give out_valid at T+k+1.

Reset
REQ-039 rst=1 SHALL immediately, without waiting for a clock edge, set state=IDLE, set the counter and all latched registers to 0, and drive every output to 0 except in_ready, which SHALL be 1.
REQ-040 rst asserted during REQ SHALL drop mem_req at once; a late mem_ack SHALL be ignored.
REQ-041 After rst deasserts, the first operation SHALL be accepted on the first rising edge that has in_valid=1.

Verification
REQ-042 Pass-through: mem_en=0, alu_result=0x1234 -> out_valid one cycle later, out_data=0x1234, out_err=0, mem_req never 1.
REQ-043 Signed byte load: addr=0x80000003, mem_op=0x0, ack after 3 cycles with rdata=0x00000000_FF000000 -> mem_addr=0x80000000, out_data=0xFFFFFFFF_FFFFFFFF; with mem_op=0x4 -> out_data=0xFF.
REQ-044 Half store: addr=0x6, store_data=0xABCD, mem_op=0x9 -> mem_wmask=0xC0, mem_wdata=0xABCD<<48, mem_we=1, out_data=0.
REQ-045 Misaligned word load: addr=0x2, mem_op=0x2 -> out_err=1 with no mem_req; timeout: TIMEOUT_CYCLES=4 and no ack -> out_err=1 on the 5th cycle after acceptance; ack on the expiry cycle -> out_err=0.
REQ-046 Backpressure and reset: hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0; assert rst mid-REQ -> mem_req=0 and in_ready=1 with no clock edge.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit: takes one operation from the ALU stage, runs at most one
// bus access for it, and hands a single result to writeback.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_en,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic [3:0]  mem_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both 1; valid never depends on ready, and a raised out_valid with its
  // out_data/out_err stays put until that transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] addr_q;
  logic [63:0] sdata_q;
  logic [63:0] res_q;
  logic [3:0]  op_q;
  logic        en_q;
  logic        err_q;
  logic [7:0]  tmo_q;

  logic        accept;
  logic        misaligned_in;
  logic        timeout_hit;
  logic [7:0]  size_mask;
  logic [63:0] lane;
  logic [63:0] load_val;
  logic        sx;

  assign accept      = in_valid & in_ready;
  assign timeout_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    misaligned_in = 1'b0;
    case (mem_op[1:0])
      2'd0: misaligned_in = 1'b0;
      2'd1: misaligned_in = alu_result[0];
      2'd2: misaligned_in = |alu_result[1:0];
      2'd3: misaligned_in = |alu_result[2:0];
      default: misaligned_in = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = 8'h01;
    case (op_q[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  // Move the addressed bytes down to bit 0, then extend by access size.
  assign lane = mem_rdata >> {addr_q[2:0], 3'b000};
  assign sx   = ~op_q[2];

  always_comb begin
    load_val = 64'd0;
    case (op_q[1:0])
      2'd0: load_val = {{56{sx & lane[7]}},  lane[7:0]};
      2'd1: load_val = {{48{sx & lane[15]}}, lane[15:0]};
      2'd2: load_val = {{32{sx & lane[31]}}, lane[31:0]};
      2'd3: load_val = lane;
      default: load_val = 64'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an ack in the expiry cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (!mem_en || misaligned_in) ? DONE : REQ;
      REQ:  if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    mem_req   = (state == REQ) & en_q;
    mem_we    = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    mem_wmask = 8'd0;
    out_valid = (state == DONE);
    out_data  = 64'd0;
    out_err   = 1'b0;
    dbg_state = state;
    if (state == REQ) begin
      mem_addr = {addr_q[63:3], 3'b000};
      if (op_q[3]) begin
        mem_we    = 1'b1;
        mem_wdata = sdata_q << {addr_q[2:0], 3'b000};
        mem_wmask = size_mask << addr_q[2:0];
      end
    end
    if (state == DONE) begin
      out_data = res_q;
      out_err  = err_q;
    end
  end

  // Operation latch, result capture and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 64'd0;
      sdata_q <= 64'd0;
      res_q   <= 64'd0;
      op_q    <= 4'd0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 8'd0;
    end else if (state == IDLE) begin
      if (accept) begin
        addr_q  <= alu_result;
        sdata_q <= store_data;
        op_q    <= mem_op;
        en_q    <= mem_en;
        res_q   <= mem_en ? 64'd0 : alu_result;
        err_q   <= mem_en & misaligned_in;
        tmo_q   <= 8'd0;
      end
    end else if (state == REQ) begin
      if (mem_ack) begin
        res_q <= op_q[3] ? 64'd0 : load_val;
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        res_q <= 64'd0;
        err_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: transaction-level timeline model drives the DUT and
// publishes per-cycle expectations; a single process compares them.
module tb_lsu_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_en = 1'b0;
  logic [63:0] alu_result = '0;
  logic [63:0] store_data = '0;
  logic [3:0]  mem_op = '0;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_err;
  logic [1:0]  dbg_state;

  lsu_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_en(mem_en), .alu_result(alu_result), .store_data(store_data),
    .mem_op(mem_op), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en    = 1'b0;
  logic        rst_probe = 1'b0;
  logic        exp_in_ready = 1'b1;
  logic        exp_req   = 1'b0;
  logic        exp_we    = 1'b0;
  logic [63:0] exp_addr  = '0;
  logic [63:0] exp_wdata = '0;
  logic [7:0]  exp_wmask = '0;
  logic        exp_valid = 1'b0;
  logic [63:0] exp_data  = '0;
  logic        exp_err   = 1'b0;

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [3:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic logic m_mis(input logic [2:0] off, input logic [3:0] op);
    return (int'(off) % m_bytes(op)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [2:0] off,
                                         input logic [3:0] op);
    int nb;
    logic [63:0] keep, v;
    nb   = m_bytes(op);
    keep = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
    v    = (rdata >> (8 * int'(off))) & keep;
    if (!op[2] && v[8 * nb - 1]) v = v | ~keep;
    return v;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [2:0] off);
    return sd << (8 * int'(off));
  endfunction

  function automatic logic [7:0] m_wmask(input logic [2:0] off, input logic [3:0] op);
    logic [15:0] m;
    m = ((16'd1 << m_bytes(op)) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // hand-computed literals that pin the model
    chk("pin_load_sb", m_load(64'h00000000_FF000000, 3'd3, 4'h0), 64'hFFFFFFFF_FFFFFFFF);
    chk("pin_load_ub", m_load(64'h00000000_FF000000, 3'd3, 4'h4), 64'h00000000_000000FF);
    chk("pin_load_sh", m_load(64'h8001_0000_0000_0000, 3'd6, 4'h1), 64'hFFFFFFFF_FFFF8001);
    chk("pin_wmask_h", 64'(m_wmask(3'd6, 4'h9)), 64'hC0);
    chk("pin_wdata_h", m_wdata(64'hABCD, 3'd6), 64'hABCD0000_00000000);
    chk("pin_mis_w", 64'(m_mis(3'd2, 4'h2)), 64'd1);
    chk("pin_mis_b", 64'(m_mis(3'd3, 4'h0)), 64'd0);
    forever begin
      @(negedge clk or posedge rst_probe);
      if (rst_probe) begin
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
      end else if (chk_en && !rst) begin
        chk("in_ready", 64'(in_ready), 64'(exp_in_ready));
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_req) begin
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_we", 64'(mem_we), 64'(exp_we));
          chk("mem_wdata", mem_wdata, exp_wdata);
          chk("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
        end
        if (exp_valid) begin
          chk("out_data", out_data, exp_data);
          chk("out_err", 64'(out_err), 64'(exp_err));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_exp_idle();
    exp_in_ready = 1'b1;
    exp_req      = 1'b0;
    exp_valid    = 1'b0;
  endtask

  task automatic probe_reset();
    rst_probe = 1'b1;
    #1;
    rst_probe = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_exp_idle();
      in_valid   = 1'b0;
      mem_en     = 1'($urandom);
      alu_result = rnd64();
      mem_op     = 4'($urandom);
      mem_ack    = 1'($urandom);
      mem_rdata  = rnd64();
      @(posedge clk); #1;
    end
  endtask

  // One whole operation; called #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic en, input logic [63:0] addr, input logic [63:0] sd,
                        input logic [3:0] op, input int ack_at, input logic [63:0] rdata,
                        input int bp);
    logic [63:0] res;
    logic        err;
    logic        got;
    set_exp_idle();
    in_valid   = 1'b1;
    mem_en     = en;
    alu_result = addr;
    store_data = sd;
    mem_op     = op;
    mem_ack    = 1'($urandom);
    mem_rdata  = rnd64();
    @(posedge clk); #1;
    // scramble the inputs so only latched values can produce the right answer
    in_valid   = 1'b0;
    mem_en     = 1'($urandom);
    alu_result = rnd64();
    store_data = rnd64();
    mem_op     = 4'($urandom);
    res = 64'd0;
    err = 1'b0;
    if (!en) begin
      res = addr;
    end else if (m_mis(addr[2:0], op)) begin
      err = 1'b1;
    end else begin
      got = 1'b0;
      err = 1'b1;
      for (int k = 0; k < TMO && !got; k++) begin
        exp_in_ready = 1'b0;
        exp_req      = 1'b1;
        exp_valid    = 1'b0;
        exp_addr     = {addr[63:3], 3'b000};
        exp_we       = op[3];
        exp_wdata    = op[3] ? m_wdata(sd, addr[2:0]) : 64'd0;
        exp_wmask    = op[3] ? m_wmask(addr[2:0], op) : 8'd0;
        mem_ack      = (k == ack_at);
        mem_rdata    = (k == ack_at) ? rdata : rnd64();
        @(posedge clk); #1;
        if (k == ack_at) begin
          got = 1'b1;
          err = 1'b0;
          res = op[3] ? 64'd0 : m_load(rdata, addr[2:0], op);
        end
      end
    end
    for (int i = 0; i <= bp; i++) begin
      exp_in_ready = 1'b0;
      exp_req      = 1'b0;
      exp_valid    = 1'b1;
      exp_data     = res;
      exp_err      = err;
      mem_ack      = 1'($urandom);
      mem_rdata    = rnd64();
      out_ready    = (i == bp);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    mem_ack   = 1'b0;
    set_exp_idle();
  endtask

  task automatic reset_mid_req();
    set_exp_idle();
    in_valid   = 1'b1;
    mem_en     = 1'b1;
    alu_result = 64'h0000_0000_0000_2000;
    mem_op     = 4'h3;
    mem_ack    = 1'b0;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    exp_in_ready = 1'b0;
    exp_req      = 1'b1;
    exp_addr     = 64'h2000;
    exp_we       = 1'b0;
    exp_wdata    = 64'd0;
    exp_wmask    = 8'd0;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    probe_reset();
    set_exp_idle();
    mem_ack   = 1'b1;
    mem_rdata = rnd64();
    @(posedge clk); #1;
    rst = 1'b0;
    // a late ack arriving in IDLE must be ignored
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    probe_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    set_exp_idle();

    run_op(1'b0, 64'h1234, rnd64(), 4'h3, 0, 64'd0, 0);
    run_op(1'b1, 64'h8000_0003, rnd64(), 4'h0, 2, 64'h00000000_FF000000, 0);
    run_op(1'b1, 64'h8000_0003, rnd64(), 4'h4, 2, 64'h00000000_FF000000, 0);
    run_op(1'b1, 64'h6, 64'hABCD, 4'h9, 1, rnd64(), 0);
    run_op(1'b1, 64'h2, rnd64(), 4'h2, 0, rnd64(), 0);
    run_op(1'b1, 64'h100, rnd64(), 4'h3, 99, rnd64(), 0);
    run_op(1'b1, 64'h108, rnd64(), 4'h3, TMO - 1, 64'h0123_4567_89AB_CDEF, 0);
    run_op(1'b1, 64'h10, rnd64(), 4'h3, 0, 64'hFEDC_BA98_7654_3210, 0);
    run_op(1'b0, 64'hCAFE, rnd64(), 4'h0, 0, 64'd0, 5);
    reset_mid_req();
    run_op(1'b1, 64'h44, 64'hDEAD_BEEF, 4'hA, 0, rnd64(), 1);

    for (int n = 0; n < 200; n++) begin
      logic [63:0] a;
      logic [3:0]  op;
      op = 4'($urandom);
      a  = rnd64();
      if ($urandom_range(0, 2) != 0) a[2:0] = a[2:0] & ~3'(m_bytes(op) - 1);
      run_op(($urandom_range(0, 5) != 0), a, rnd64(), op,
             $urandom_range(0, TMO + 1), rnd64(), $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
